rng_client: RTL and testbench
=============================

# rng_client

Requester-side companion to the word-assembling RNG collector: it drives `rng_req`, captures each `rng_word` on its one-cycle `rng_valid` pulse, and buffers words in a small show-ahead FIFO for downstream key/nonce logic on a valid/ready port. It sits between the RNG collector and the HSM crypto datapath. It also flags a stalled generator (timeout) and can optionally flag stuck entropy (repetition-count test).

## Interface
- `WIDTH`, 2, random word width; must match the collector.
- `DEPTH`, 4, FIFO entries; power of two, ≥2.
- `TIMEOUT`, 255, maximum cycles in WAIT before abandoning a request; range 1..65535.
- `REP_LIMIT`, 8, number of consecutive identical words that trips the health test; ≥2.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `en` in 1: block enable; also driven to the collector's `en`.
- `rng_req` out 1: request to collector, registered.
- `rng_word` in WIDTH: word from collector.
- `rng_valid` in 1: one-cycle word-valid pulse from collector.
- `out_data` out WIDTH: FIFO head word.
- `out_valid` out 1: FIFO non-empty.
- `out_ready` in 1: consumer accepts the head word.
- `fill` out $clog2(DEPTH)+1: FIFO occupancy.
- `timeout_err` out 1: sticky; a request timed out.
- `health_fail` out 1: sticky; repetition test tripped.

## Operation
- FSM states: IDLE, WAIT.
- IDLE → WAIT when `en` && `fill` < DEPTH && !`health_fail`. `rng_req` is set in the same transition.
- WAIT, `rng_valid`=1: capture `rng_word`, clear `rng_req`, go to IDLE. The word is pushed unless the health test rejects it.
- WAIT, timer = TIMEOUT-1 with no `rng_valid`: set `timeout_err`, clear `rng_req`, reset the timer, go to IDLE. The block then retries automatically.
- WAIT, `en`=0: clear `rng_req`, go to IDLE; the request is abandoned.
- `rng_valid` outside WAIT is ignored.
- At most one request is outstanding. A request is issued only when a slot is free, so a push never overflows the FIFO.
- FIFO is show-ahead: `out_data` is the head entry, and a pop occurs on `out_valid` && `out_ready`. With simultaneous push and pop, `fill` is unchanged and the word order is preserved. A pop when empty is ignored. Pointers wrap modulo DEPTH.
- `en`=0 does not flush the FIFO; the consumer may continue draining it.
- Reset values: `rng_req`=0, `out_valid`=0, `out_data`=0, `fill`=0, `timeout_err`=0, `health_fail`=0, state IDLE, pointers 0, timer 0.
- Reset mid-WAIT drops `rng_req` on the next edge, and the FIFO contents are lost.

## Timing
- `rng_req` rises one cycle after the IDLE decision. It stays high through WAIT and falls on the edge that samples `rng_valid`=1.
- Capture-to-output latency: a word sampled at edge N is visible on `out_data`/`out_valid` after edge N (next cycle) when the FIFO was empty.
- Minimum spacing between requests: IDLE re-enters WAIT on the edge after capture, so `rng_req` is low for exactly one cycle between back-to-back words. This matches the collector's one-cycle post-valid clear.
- `timeout_err` asserts on the edge ending cycle TIMEOUT of WAIT.
- `fill` updates on the push/pop edge.

## Configuration
- Macro: `RNG_CLIENT_HEALTH_EN`.
- When defined:
  - The block keeps a last-word register and a run counter.
  - A captured word equal to the last word increments the run; a different word resets the run to 1.
  - When the run reaches REP_LIMIT, `health_fail` sets on that capture edge and that word is not pushed.
  - No further requests are issued until reset. FIFO contents already present remain poppable.
- When undefined: no comparison logic is present, `health_fail` is tied to 0, and every captured word is pushed.

## Test plan
- Basic, WIDTH=8: collector returns 0xA5 three cycles after `rng_req` rises → `out_data`=0xA5, `out_valid`=1 one cycle after capture, `fill`=1; `rng_req` low for exactly one cycle, then high again.
- Full FIFO, DEPTH=4, `out_ready`=0: after words 0x01..0x04 → `fill`=4, `rng_req` stays 0. One pop → head 0x02, `fill`=3, then `rng_req` reasserts.
- Simultaneous push/pop at `fill`=2: `fill` remains 2 and the pop order matches the push order.
- Timeout, TIMEOUT=16, no `rng_valid`: `timeout_err`=1 after 16 WAIT cycles, `rng_req` low for 1 cycle, then a retry. A late word 0x3C is then accepted and `timeout_err` stays 1.
- Health (macro on), REP_LIMIT=8: eight consecutive 0x00 words → 7 pushed, `health_fail`=1, `rng_req` held 0. Reset clears `health_fail` and `fill`.
- `en` drop mid-WAIT: `rng_req`=0 next cycle, and an `rng_valid` pulse arriving afterward is not pushed (`fill` unchanged).

Source files
------------

// File: rtl/rng_client.sv
// Requester for the RNG word collector: issues one request at a time, buffers
// captured words in a show-ahead FIFO. Optional repetition-count health test: RNG_CLIENT_HEALTH_EN.
module rng_client #(
    parameter int WIDTH     = 2,
    parameter int DEPTH     = 4,
    parameter int TIMEOUT   = 255,
    parameter int REP_LIMIT = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    output logic                   rng_req,
    input  logic [WIDTH-1:0]       rng_word,
    input  logic                   rng_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] fill,
    output logic                   timeout_err,
    output logic                   health_fail
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;
    localparam int TW = 16;

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t            state;
    logic [TW-1:0]     timer;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              capture;
    logic              reject;
    logic              push;
    logic              pop;

    // A word is only taken while a live, enabled request is outstanding.
    assign capture   = (state == WAIT) && en && rng_valid;
    assign push      = capture && !reject;
    assign out_valid = (fill != '0);
    assign pop       = out_valid && out_ready;
    assign out_data  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rng_req     <= 1'b0;
            timer       <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en && (fill < FW'(DEPTH)) && !health_fail) begin
                        state   <= WAIT;
                        rng_req <= 1'b1;
                        timer   <= '0;
                    end
                end
                WAIT: begin
                    if (!en) begin
                        state   <= IDLE;
                        rng_req <= 1'b0;
                        timer   <= '0;
                    end else if (rng_valid) begin
                        state   <= IDLE;
                        rng_req <= 1'b0;
                        timer   <= '0;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        state       <= IDLE;
                        rng_req     <= 1'b0;
                        timer       <= '0;
                        timeout_err <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    rng_req <= 1'b0;
                    timer   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= rng_word;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
        end
    end

`ifdef RNG_CLIENT_HEALTH_EN
    localparam int RW = $clog2(REP_LIMIT + 1);

    logic [WIDTH-1:0] last_word;
    logic [RW-1:0]    run;
    logic [RW-1:0]    run_next;

    // run starts at 0, so the first capture after reset always yields a run of 1.
    always_comb begin
        run_next = RW'(1);
        if (rng_word == last_word) begin
            run_next = run + 1'b1;
        end
    end

    assign reject = capture && (run_next == RW'(REP_LIMIT));

    always_ff @(posedge clk) begin
        if (reset) begin
            last_word   <= '0;
            run         <= '0;
            health_fail <= 1'b0;
        end else if (capture) begin
            last_word <= rng_word;
            run       <= run_next;
            if (reject) begin
                health_fail <= 1'b1;
            end
        end
    end
`else
    assign reject      = 1'b0;
    assign health_fail = 1'b0;
`endif

endmodule

// File: tb/tb_rng_client.sv
// Scoreboard bench for rng_client: directed collector responses, expected words
// queued at capture and checked by a monitor when the DUT presents them.
module tb_rng_client;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       rng_req;
    logic [7:0] rng_word;
    logic       rng_valid;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] fill;
    logic       timeout_err;
    logic       health_fail;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];

    rng_client #(
        .WIDTH(8),
        .DEPTH(4),
        .TIMEOUT(16),
        .REP_LIMIT(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .rng_req(rng_req),
        .rng_word(rng_word),
        .rng_valid(rng_valid),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .fill(fill),
        .timeout_err(timeout_err),
        .health_fail(health_fail)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Monitor: every word the consumer accepts must be the oldest expected one.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL pop_unexpected: got %0h expected none", out_data);
            end else begin
                chk("pop_order", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string name);
        for (int i = 0; i < 100; i++) begin
            if (rng_req === 1'b1) break;
            step();
        end
        chk(name, {31'd0, rng_req}, 32'd1);
    endtask

    task automatic send(input logic [7:0] w, input bit pushed);
        wait_req("req_before_word");
        rng_word  = w;
        rng_valid = 1'b1;
        if (pushed) exp_q.push_back(w);
        step();
        rng_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; en = 1'b0; rng_valid = 1'b0; rng_word = 8'h00; out_ready = 1'b0;
        repeat (3) step();
        chk("rst_req", {31'd0, rng_req}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", {24'd0, out_data}, 32'd0);
        chk("rst_fill", {29'd0, fill}, 32'd0);
        chk("rst_timeout", {31'd0, timeout_err}, 32'd0);
        chk("rst_health", {31'd0, health_fail}, 32'd0);
        reset = 1'b0;
        step();

        // Basic capture: word three cycles after the request rises.
        en = 1'b1;
        wait_req("basic_req");
        step();
        step();
        rng_word = 8'hA5; rng_valid = 1'b1; exp_q.push_back(8'hA5);
        step();
        rng_valid = 1'b0;
        chk("basic_data", {24'd0, out_data}, 32'hA5);
        chk("basic_valid", {31'd0, out_valid}, 32'd1);
        chk("basic_fill", {29'd0, fill}, 32'd1);
        chk("basic_req_gap", {31'd0, rng_req}, 32'd0);
        step();
        chk("basic_req_again", {31'd0, rng_req}, 32'd1);

        // Enable drop mid-WAIT abandons the request; a late pulse is ignored.
        en = 1'b0;
        step();
        chk("en_drop_req", {31'd0, rng_req}, 32'd0);
        rng_word = 8'hEE; rng_valid = 1'b1;
        step();
        rng_valid = 1'b0;
        step();
        chk("en_drop_fill", {29'd0, fill}, 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("drain1_fill", {29'd0, fill}, 32'd0);

        // Fill the FIFO with no consumer.
        en = 1'b1;
        for (int w = 1; w <= 4; w++) send(8'(w), 1'b1);
        repeat (4) step();
        chk("full_fill", {29'd0, fill}, 32'd4);
        chk("full_no_req", {31'd0, rng_req}, 32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("full_head", {24'd0, out_data}, 32'h02);
        chk("full_fill_after_pop", {29'd0, fill}, 32'd3);
        wait_req("full_req_again");

        // Simultaneous push and pop at fill 2.
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("pre_simul_fill", {29'd0, fill}, 32'd2);
        out_ready = 1'b1; rng_word = 8'h55; rng_valid = 1'b1; exp_q.push_back(8'h55);
        step();
        rng_valid = 1'b0; out_ready = 1'b0;
        chk("simul_fill", {29'd0, fill}, 32'd2);
        en = 1'b0; out_ready = 1'b1;
        repeat (3) step();
        out_ready = 1'b0;
        chk("drain2_fill", {29'd0, fill}, 32'd0);
        chk("drain2_queue", exp_q.size(), 32'd0);

        // Timeout after 16 WAIT cycles, then automatic retry.
        en = 1'b1;
        wait_req("to_req");
        repeat (15) step();
        chk("to_not_yet", {31'd0, timeout_err}, 32'd0);
        step();
        chk("to_set", {31'd0, timeout_err}, 32'd1);
        chk("to_req_low", {31'd0, rng_req}, 32'd0);
        step();
        chk("to_retry", {31'd0, rng_req}, 32'd1);
        send(8'h3C, 1'b1);
        chk("to_late_fill", {29'd0, fill}, 32'd1);
        chk("to_sticky", {31'd0, timeout_err}, 32'd1);
        en = 1'b0; out_ready = 1'b1;
        repeat (2) step();
        chk("drain3_fill", {29'd0, fill}, 32'd0);

        // Repetition test: eight identical words.
        do_reset();
        out_ready = 1'b1; en = 1'b1;
`ifdef RNG_CLIENT_HEALTH_EN
        for (int i = 0; i < 8; i++) send(8'h00, i < 7);
        chk("health_set", {31'd0, health_fail}, 32'd1);
        repeat (4) step();
        chk("health_no_req", {31'd0, rng_req}, 32'd0);
        chk("health_queue", exp_q.size(), 32'd0);
        do_reset();
        chk("health_rst", {31'd0, health_fail}, 32'd0);
        chk("health_rst_fill", {29'd0, fill}, 32'd0);
`else
        for (int i = 0; i < 8; i++) send(8'h00, 1'b1);
        repeat (3) step();
        chk("health_off", {31'd0, health_fail}, 32'd0);
        chk("health_off_queue", exp_q.size(), 32'd0);
`endif

        // Reset while a request is outstanding.
        out_ready = 1'b0; en = 1'b1;
        wait_req("rst_wait_req");
        reset = 1'b1;
        step();
        chk("rst_mid_wait_req", {31'd0, rng_req}, 32'd0);
        reset = 1'b0;
        en = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
